// File: rtl/control_unit_if.sv
// Opcode-in / control-strobe-out bundle between the instruction register and the datapath.
interface control_unit_if;
    logic [2:0] OPCode;
    logic       J;
    logic       JC;
    logic       INA;
    logic       RM;
    logic       WM;
    logic       SIN;
    logic       SOUT;
    logic       WR;
    logic       NEQ;

    modport master (
        output OPCode,
        input  J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ
    );

    modport slave (
        input  OPCode,
        output J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ
    );
endinterface

// File: rtl/control_unit.sv
// Three-state FETCH/DECODE/EXECUTE sequencer: captures the opcode at the end of DECODE
// and drives one-clock registered control strobes during EXECUTE.
module control_unit (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2
    } state_t;

    typedef struct packed {
        logic j;
        logic jc;
        logic ina;
        logic rm;
        logic wm;
        logic sin;
        logic sout;
        logic wr;
        logic neq;
    } strobe_t;

    state_t     state_q, state_d;
    logic [2:0] opc_q, opc_d;
    strobe_t    strb_q, strb_d;

    // Opcode to strobe map; each entry sets at most one of J/JC and one of RM/WM.
    function automatic strobe_t decode(input logic [2:0] op);
        strobe_t s;
        s = '0;
        case (op)
            3'b000: s.wr = 1'b1;
            3'b001: begin s.ina = 1'b1; s.wr = 1'b1; end
            3'b010: begin s.rm  = 1'b1; s.wr = 1'b1; end
            3'b011: s.wm = 1'b1;
            3'b100: begin s.sin = 1'b1; s.wr = 1'b1; end
            3'b101: s.sout = 1'b1;
            3'b110: begin s.jc  = 1'b1; s.neq = 1'b1; end
            3'b111: s.j = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Strobes are computed on the DECODE->EXECUTE edge so they are valid for all of EXECUTE.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        strb_d  = '0;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                state_d = EXECUTE;
                if ($isunknown(bus.OPCode)) begin
                    opc_d = 3'b000;
                end else begin
                    opc_d  = bus.OPCode;
                    strb_d = decode(bus.OPCode);
                end
            end
            EXECUTE: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            opc_q   <= 3'b000;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            strb_q  <= strb_d;
        end
    end

    assign bus.J    = strb_q.j;
    assign bus.JC   = strb_q.jc;
    assign bus.INA  = strb_q.ina;
    assign bus.RM   = strb_q.rm;
    assign bus.WM   = strb_q.wm;
    assign bus.SIN  = strb_q.sin;
    assign bus.SOUT = strb_q.sout;
    assign bus.WR   = strb_q.wr;
    assign bus.NEQ  = strb_q.neq;

endmodule

// File: tb/tb_control_unit.sv
// Directed and random bench for control_unit using an expected-strobe queue.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [8:0] exp_q[$];

    control_unit_if bus();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Bit order {J,JC,INA,RM,WM,SIN,SOUT,WR,NEQ}
    function automatic logic [8:0] model(input logic [2:0] op);
        if ($isunknown(op)) return 9'b0;
        case (op)
            3'b000: return 9'b000000010;
            3'b001: return 9'b001000010;
            3'b010: return 9'b000100010;
            3'b011: return 9'b000010000;
            3'b100: return 9'b000001010;
            3'b101: return 9'b000000100;
            3'b110: return 9'b010000001;
            default: return 9'b100000000;
        endcase
    endfunction

    function automatic logic [8:0] outs();
        return {bus.J, bus.JC, bus.INA, bus.RM, bus.WM, bus.SIN, bus.SOUT, bus.WR, bus.NEQ};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic check_excl(input string tag);
        logic [8:0] o;
        o = outs();
        tests_run++;
        assert (!(o[8] && o[7]) && !(o[5] && o[4])) else begin
            tests_failed++;
            $error("FAIL %s obs=%b exp=no J&JC, no RM&WM", tag, o);
        end
    endtask

    // Entered just after an edge with the DUT in FETCH; returns just after the edge leaving EXECUTE.
    task automatic run_instr(input string tag, input logic [2:0] fetch_op,
                             input logic [2:0] op, input logic [2:0] late_op);
        logic [8:0] e;
        bus.OPCode = fetch_op;
        check({tag, "_fetch"}, outs(), 9'b0);
        @(posedge clk); #1;
        bus.OPCode = op;
        check({tag, "_decode"}, outs(), 9'b0);
        exp_q.push_back(model(op));
        @(posedge clk); #1;
        bus.OPCode = late_op;
        e = exp_q.pop_front();
        check({tag, "_exec"}, outs(), e);
        check_excl({tag, "_excl"});
        @(negedge clk); #1;
        check({tag, "_exec_hold"}, outs(), e);
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.OPCode   = 3'b111;

        // Held reset with JMP on the bus: nothing moves
        #1;
        check("reset_async", outs(), 9'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("reset_hold", outs(), 9'b0);
        end
        rst_n = 1'b1;
        run_instr("release_jmp", 3'b111, 3'b111, 3'b111);

        // Opcode sweep
        for (int i = 0; i < 8; i++) begin
            run_instr("sweep", 3'(7 - i), 3'(i), 3'(7 - i));
        end

        // Late change to ADD during EXECUTE must not disturb STORE
        run_instr("late_change", 3'b000, 3'b011, 3'b000);

        // Async reset in the middle of an ADDI EXECUTE
        bus.OPCode = 3'b001;
        check("mid_rst_fetch", outs(), 9'b0);
        @(posedge clk); #1;
        check("mid_rst_decode", outs(), 9'b0);
        exp_q.push_back(model(3'b001));
        @(posedge clk); #1;
        check("mid_rst_exec", outs(), exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1 check("mid_rst_drop", outs(), 9'b0);
        #2 rst_n = 1'b1;
        run_instr("after_rst", 3'b001, 3'b000, 3'b001);

        // Unknown opcode at capture
        run_instr("x_opcode", 3'b111, 3'bxxx, 3'b111);

        // Random opcodes
        for (int i = 0; i < 1000; i++) begin
            run_instr("random", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)));
        end

        tests_run++;
        assert (exp_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL queue_empty obs=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
